// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, drives the
//                combinational instruction ROM (rom_ce / rom_addr), captures
//                each fetched word with its PC into a small skid FIFO and
//                presents the FIFO head to decode over valid/ready.
//                Branch redirects and exception flushes empty the FIFO and
//                reload the PC (flush has priority over branch).
//  Ports       :
//    clk           in   single clock, rising edge
//    rst           in   asynchronous active-low reset
//    rom_ce        out  ROM chip enable (combinational)
//    rom_addr      out  ROM byte address (= pc)
//    rom_inst      in   ROM read data, valid in the same cycle
//    id_ready      in   decode accepts the head entry
//    if_valid      out  head entry valid
//    if_pc         out  PC of head entry
//    if_inst       out  instruction of head entry
//    branch_flag   in   redirect request from decode
//    branch_target in   redirect PC
//    flush         in   exception / pipeline flush
//    new_pc        in   flush PC
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(3);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
  logic [ADDR_W-1:0] mem_pc_d   [DEPTH];
  logic [INST_W-1:0] mem_inst_q [DEPTH];
  logic [INST_W-1:0] mem_inst_d [DEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              push;
  logic              pop;

  // Head outputs come straight from storage so decode never sees a
  // combinational path from the ROM or from id_ready.
  assign if_valid = (count_q != '0);
  assign if_pc    = mem_pc_q[rd_ptr_q];
  assign if_inst  = mem_inst_q[rd_ptr_q];
  assign rom_addr = pc_q;
  assign rom_ce   = push;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_pc_d    = mem_pc_q;
    mem_inst_d  = mem_inst_q;

    redirect    = flush | branch_flag;
    // Low two address bits are silently dropped: fetch is word aligned.
    redirect_pc = (flush ? new_pc : branch_target) & c_align_mask;
    pop         = if_valid & id_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still fetches.
    push        = (state_q == S_RUN) & ~redirect & ((count_q < c_depth_cnt) | pop);

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      // Redirect discards every queued entry, including any pop this cycle.
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_pc_d[wr_ptr_q]   = pc_q;
        mem_inst_d[wr_ptr_q] = rom_inst;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        pc_d                 = pc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_pc_q   <= '{default: '0};
      mem_inst_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_pc_q   <= mem_pc_d;
      mem_inst_q <= mem_inst_d;
    end
  end

endmodule
`default_nettype wire
